// File: rtl/airlock_timer_pkg.sv
// Shared airlock definitions: timer ownership states, elapsed-unit counter
// width and its saturation value. Also used by the arriving and leaving
// sequencers so they agree on the encoding.
package airlock_timer_pkg;

    // Which sequencer currently owns the shared timer.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEAVE  = 2'd1,
        ARRIVE = 2'd2
    } own_state_t;

    localparam int unsigned COUNT_W = 3;
    localparam logic [COUNT_W-1:0] COUNT_SAT = 3'b111;

    // Increment that sticks at COUNT_SAT instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
        return (value == COUNT_SAT) ? value : value + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/airlock_prescaler.sv
// Unit prescaler: divides the clock by TICKS_PER_UNIT while enabled.
// Ports:
//   clock  - system clock, rising edge
//   rst    - synchronous active-high reset
//   clear  - restart the count from 0 at the next edge, no tick this cycle
//   enable - count while high; held at 0 while low
//   tick   - combinational, high in the last cycle of each unit
module airlock_prescaler #(
    parameter int unsigned TICKS_PER_UNIT = 4
) (
    input  logic clock,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_UNIT - 1);

    logic [PW-1:0] count;

    // A clear or reset in the same cycle wins over the tick.
    assign tick = enable && !clear && !rst && (count == LAST);

    always_ff @(posedge clock) begin
        if (rst || clear || !enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + PW'(1);
        end
    end

endmodule

// File: rtl/airlock_timer.sv
// Shared airlock elapsed-time counter arbitrated between the leaving and
// arriving sequencers.
// Ports:
//   clock, rst                  - system clock, synchronous active-high reset
//   reqLeave, reqArrive         - ownership requests, held for a whole sequence
//   rstCounterLeave/Arrive      - counter-restart pulses from each sequencer
//   counterVal                  - elapsed units since last accepted restart, saturating
//   grantLeave, grantArrive     - current owner (at most one high)
//   unitTick                    - combinational pulse on each increment attempt
//   conflict                    - sticky: restart pulse seen from a non-owner
module airlock_timer
    import airlock_timer_pkg::*;
#(
    parameter int unsigned TICKS_PER_UNIT = 4
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               reqLeave,
    input  logic               reqArrive,
    input  logic               rstCounterLeave,
    input  logic               rstCounterArrive,
    output logic [COUNT_W-1:0] counterVal,
    output logic               grantLeave,
    output logic               grantArrive,
    output logic               unitTick,
    output logic               conflict
);

    own_state_t state;

    logic granted;
    logic enter_leave;
    logic enter_arrive;
    logic own_leave;
    logic own_arrive;
    logic releasing;
    logic restart;
    logic bad_pulse;

    assign granted      = (state != IDLE);
    assign enter_arrive = (state == IDLE) && reqArrive;
    assign enter_leave  = (state == IDLE) && !reqArrive && reqLeave;

    // A sequencer being granted from IDLE this cycle already counts as the
    // owner, so its restart pulse is accepted rather than flagged.
    assign own_leave  = (state == LEAVE)  || enter_leave;
    assign own_arrive = (state == ARRIVE) || enter_arrive;

    assign releasing = ((state == LEAVE)  && !reqLeave) ||
                       ((state == ARRIVE) && !reqArrive);

    assign restart   = (rstCounterLeave && own_leave) || (rstCounterArrive && own_arrive);
    assign bad_pulse = (rstCounterLeave && !own_leave) || (rstCounterArrive && !own_arrive);

    assign grantLeave  = (state == LEAVE);
    assign grantArrive = (state == ARRIVE);

    // Prescaler sits at 0 through IDLE, so entering a grant always starts a fresh unit.
    airlock_prescaler #(
        .TICKS_PER_UNIT(TICKS_PER_UNIT)
    ) u_prescaler (
        .clock (clock),
        .rst   (rst),
        .clear (!granted || restart),
        .enable(granted),
        .tick  (unitTick)
    );

    // Ownership FSM, saturating counter and sticky conflict flag.
    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= IDLE;
            counterVal <= '0;
            conflict   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqArrive) begin
                        state <= ARRIVE;
                    end else if (reqLeave) begin
                        state <= LEAVE;
                    end
                end
                LEAVE: begin
                    if (!reqLeave) begin
                        state <= IDLE;
                    end
                end
                ARRIVE: begin
                    if (!reqArrive) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (!granted || releasing || restart) begin
                counterVal <= '0;
            end else if (unitTick) begin
                counterVal <= sat_inc(counterVal);
            end

            conflict <= conflict || bad_pulse;
        end
    end

endmodule

// File: tb/tb_airlock_timer.sv
// Bench for airlock_timer: directed and random stimulus, expected outputs
// from an elapsed-cycle reference model queued per cycle and popped by an
// independent monitor on the falling edge.
module tb_airlock_timer;

    localparam int unsigned T = 4;

    logic       clock = 1'b0;
    logic       rst;
    logic       reqLeave;
    logic       reqArrive;
    logic       rstCounterLeave;
    logic       rstCounterArrive;
    logic [2:0] counterVal;
    logic       grantLeave;
    logic       grantArrive;
    logic       unitTick;
    logic       conflict;

    typedef struct packed {
        logic [2:0] cnt;
        logic       gl;
        logic       ga;
        logic       tick;
        logic       conf;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   started     = 1'b0;

    // Reference model: owner 0=none 1=leave 2=arrive; m_c = cycles since the
    // grant edge or the last accepted restart edge.
    int m_owner;
    int m_c;
    bit m_conf;

    always #5 clock = ~clock;

    airlock_timer #(.TICKS_PER_UNIT(T)) dut (
        .clock           (clock),
        .rst             (rst),
        .reqLeave        (reqLeave),
        .reqArrive       (reqArrive),
        .rstCounterLeave (rstCounterLeave),
        .rstCounterArrive(rstCounterArrive),
        .counterVal      (counterVal),
        .grantLeave      (grantLeave),
        .grantArrive     (grantArrive),
        .unitTick        (unitTick),
        .conflict        (conflict)
    );

    // Apply one cycle of inputs, queue this cycle's expected outputs, advance the model.
    task automatic drive(input bit r, input bit rl, input bit ra, input bit pl, input bit pa);
        obs_t e;
        int   taker;
        int   nxt;
        int   units;
        bit   acc;
        bit   bad;
        rst              = r;
        reqLeave         = rl;
        reqArrive        = ra;
        rstCounterLeave  = pl;
        rstCounterArrive = pa;

        if (m_owner == 0) taker = ra ? 2 : (rl ? 1 : 0);
        else              taker = m_owner;
        if (m_owner == 0)      nxt = taker;
        else if (m_owner == 1) nxt = rl ? 1 : 0;
        else                   nxt = ra ? 2 : 0;
        acc = (taker == 1 && pl) || (taker == 2 && pa);
        bad = (pl && taker != 1) || (pa && taker != 2);

        units = (m_owner == 0) ? 0 : m_c / int'(T);
        if (units > 7) units = 7;
        e.cnt  = 3'(units);
        e.gl   = (m_owner == 1);
        e.ga   = (m_owner == 2);
        e.tick = !r && (m_owner != 0) && !acc && ((m_c % int'(T)) == int'(T) - 1);
        e.conf = m_conf;
        exp_q.push_back(e);

        if (r) begin
            m_owner = 0;
            m_c     = 0;
            m_conf  = 1'b0;
        end else begin
            m_c     = (m_owner == 0 || nxt == 0 || acc) ? 0 : m_c + 1;
            m_owner = nxt;
            m_conf  = m_conf || bad;
        end

        @(posedge clock);
        #1;
    endtask

    // Monitor: every cycle presents a full output set; compare against the queue head.
    initial begin
        forever begin
            @(negedge clock);
            if (started) begin
                obs_t a;
                obs_t e;
                a = {counterVal, grantLeave, grantArrive, unitTick, conflict};
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL no_expect t=%0t got cnt=%0d gl=%b ga=%b tick=%b conf=%b",
                             $time, a.cnt, a.gl, a.ga, a.tick, a.conf);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        miscompares++;
                        $display("FAIL outputs t=%0t got cnt=%0d gl=%b ga=%b tick=%b conf=%b want cnt=%0d gl=%b ga=%b tick=%b conf=%b",
                                 $time, a.cnt, a.gl, a.ga, a.tick, a.conf,
                                 e.cnt, e.gl, e.ga, e.tick, e.conf);
                    end
                end
            end
        end
    end

    initial begin
        int tog[4]  = '{40, 20, 60, 30};
        int pdiv[4] = '{50, 15, 0, 25};
        int rdiv[4] = '{250, 120, 0, 400};
        bit rl;
        bit ra;
        bit pl;
        bit pa;
        bit r;

        rst = 1'b1; reqLeave = 1'b0; reqArrive = 1'b0;
        rstCounterLeave = 1'b0; rstCounterArrive = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        m_owner = 0; m_c = 0; m_conf = 1'b0;
        started = 1'b1;

        // Directed: reset state, grant, count to saturation and hold.
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 36; i++) drive(0, 1, 0, 0, 0);
        // Owner restart, then count again.
        drive(0, 1, 0, 1, 0);
        for (int i = 0; i < 10; i++) drive(0, 1, 0, 0, 0);
        // Non-owner pulse: conflict, count unaffected; stays set through IDLE.
        drive(0, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);
        // Reset together with owner restart at counterVal=5.
        for (int i = 0; i < 22; i++) drive(0, 1, 0, 0, 0);
        drive(1, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
        // Simultaneous requests: arrive wins, then leave after one IDLE cycle.
        for (int i = 0; i < 9; i++) drive(0, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) drive(0, 1, 0, 0, 0);
        // Release at counterVal=1, pulse while in IDLE, restart on the grant cycle.
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1);
        for (int i = 0; i < 14; i++) drive(0, 0, 1, 0, 0);
        drive(0, 1, 1, 1, 1);
        for (int i = 0; i < 6; i++) drive(0, 0, 1, 0, 0);

        // Random phases with varying request, pulse and reset densities.
        rl = 1'b0;
        ra = 1'b0;
        for (int p = 0; p < 4; p++) begin
            for (int n = 0; n < 1500; n++) begin
                if (($urandom % tog[p]) == 0) rl = !rl;
                if (($urandom % tog[p]) == 0) ra = !ra;
                pl = (pdiv[p] != 0) && (($urandom % pdiv[p]) == 0);
                pa = (pdiv[p] != 0) && (($urandom % pdiv[p]) == 0);
                r  = (rdiv[p] != 0) && (($urandom % rdiv[p]) == 0);
                drive(r, rl, ra, pl, pa);
            end
        end

        started = 1'b0;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_expect got %0d queued want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
